// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic a_signed(input funct3_e f);
    return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
  endfunction

  function automatic logic b_signed(input funct3_e f);
    return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add / restoring divide on
// magnitudes over a single 64-bit accumulator, sign fix-up on DONE entry.
module muldiv_unit #(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import muldiv_pkg::state_e;
  import muldiv_pkg::funct3_e;
  import muldiv_pkg::ITER;
  import muldiv_pkg::CNT_W;
  import muldiv_pkg::a_signed;
  import muldiv_pkg::b_signed;
  import muldiv_pkg::IDLE;
  import muldiv_pkg::CALC;
  import muldiv_pkg::DONE;
  import muldiv_pkg::F3_MUL;
  import muldiv_pkg::F3_MULH;
  import muldiv_pkg::F3_MULHSU;
  import muldiv_pkg::F3_MULHU;
  import muldiv_pkg::F3_DIV;
  import muldiv_pkg::F3_DIVU;
  import muldiv_pkg::F3_REM;
  import muldiv_pkg::F3_REMU;

  state_e              state, state_nx;
  funct3_e             f3;
  logic [XLEN-1:0]     b_mag;
  logic                neg;
  logic                byp;
  logic [2*XLEN-1:0]   acc;
  logic [CNT_W-1:0]    cnt;

  // ---- request decode (IDLE-side) ----
  funct3_e         f_in;
  logic            a_neg_in, b_neg_in, div0_in, ovf_in, byp_in, neg_in;
  logic [XLEN-1:0] a_mag_in, b_mag_in, special_in;

  always_comb begin
    f_in     = funct3_e'(funct3);
    a_neg_in = a_signed(f_in) & op_a[XLEN-1];
    b_neg_in = b_signed(f_in) & op_b[XLEN-1];
    a_mag_in = a_neg_in ? -op_a : op_a;
    b_mag_in = b_neg_in ? -op_b : op_b;
    div0_in  = f_in[2] && (op_b == '0);
    ovf_in   = ((f_in == F3_DIV) || (f_in == F3_REM)) &&
               (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    byp_in   = div0_in || ovf_in;
    // remainder follows the dividend; everything else follows sign(a)^sign(b)
    neg_in   = (f_in[2] && f_in[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);
    if (div0_in)
      special_in = f_in[1] ? op_a : '1;
    else
      special_in = f_in[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // ---- one radix-2 step ----
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  logic [XLEN:0]     div_tmp, div_diff;
  logic [2*XLEN-1:0] div_step;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
    mul_step = {mul_sum, acc[XLEN-1:1]};
    // partial remainder < divisor, so the shifted value minus divisor never
    // reaches bit XLEN unless it borrowed
    div_tmp  = acc[2*XLEN-1:XLEN-1];
    div_diff = div_tmp - {1'b0, b_mag};
    if (div_diff[XLEN])
      div_step = {div_tmp[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      div_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  // ---- final sign fix-up and selection ----
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fin;

  always_comb begin
    prod = neg ? -acc : acc;
    quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    fin  = acc[XLEN-1:0];
    if (!byp) begin
      case (f3)
        F3_MUL:                        fin = prod[XLEN-1:0];
        F3_MULH, F3_MULHSU, F3_MULHU:  fin = prod[2*XLEN-1:XLEN];
        F3_DIV, F3_DIVU:               fin = quo;
        F3_REM, F3_REMU:               fin = rem;
        default:                       fin = acc[XLEN-1:0];
      endcase
    end
  end

  // ---- FSM ----
  logic last_step;
  assign last_step = byp || (cnt == CNT_W'(ITER));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (last_step) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---- datapath ----
  // Bypassed divides still spend one cycle in CALC, which holds the
  // precomputed special result in acc and lands done on the second edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3     <= F3_MUL;
      b_mag  <= '0;
      neg    <= 1'b0;
      byp    <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          f3    <= f_in;
          b_mag <= b_mag_in;
          neg   <= neg_in;
          byp   <= byp_in;
          cnt   <= '0;
          acc   <= {{XLEN{1'b0}}, (byp_in ? special_in : a_mag_in)};
        end
        CALC: begin
          if (last_step) begin
            result <= fin;
          end else begin
            acc <= f3[2] ? div_step : mul_step;
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + random check of muldiv_unit against a plain-arithmetic RV32M model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_exp = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_bypass(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, q;
    logic [63:0] p;
    sa = $signed(a); sb = $signed(b);
    ua = a;          ub = b;
    case (f)
      3'b000: begin p = ua * ub; return p[31:0];  end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb; return q[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        q = ua / ub; return q[31:0];
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb; return q[31:0];
      end
      default: begin
        if (b == 0) return a;
        q = ua % ub; return q[31:0];
      end
    endcase
  endfunction

  // Call with the time between a negedge and the next posedge; returns just
  // after a negedge. poke = edge index (after E0) on which start is re-pulsed.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int poke);
    logic [31:0] exp;
    int exp_lat, n;
    logic busy_ok, hold_ok;
    exp     = ref_model(f, a, b);
    exp_lat = is_bypass(f, a, b) ? 1 : 33;
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    @(posedge clk); #1;
    busy_ok = busy; hold_ok = 1'b1; n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      if (poke != 0 && n + 1 == poke) begin
        start = 1'b1; funct3 = ~f; op_a = $urandom; op_b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (!busy) busy_ok = 1'b0;
      if (!done && result !== last_exp) hold_ok = 1'b0;
    end
    chk({tag, "_lat"},  64'(n),      64'(exp_lat));
    chk({tag, "_res"},  64'(result), 64'(exp));
    chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
    chk({tag, "_hold"}, 64'(hold_ok), 64'd1);
    // edge leaving DONE: a start here must be ignored
    @(negedge clk);
    start = (poke == n + 1);
    @(posedge clk); #1;
    chk({tag, "_idle"}, 64'({busy, done}), 64'd0);
    @(negedge clk);
    start = 1'b0;
    last_exp = exp;
  endtask

  logic [31:0] ra, rb;
  logic seen_done;

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_busy",   64'(busy),   64'd0);
    chk("rst_done",   64'(done),   64'd0);
    chk("rst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    // first edge with rst low must already accept the request
    run_op("mul_7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 0);
    run_op("mulhu_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mulh_ff",  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div_31_6", 3'b100, 32'd31, 32'd6, 0);
    run_op("rem_31_6", 3'b110, 32'd31, 32'd6, 0);
    run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu_z",   3'b101, 32'h1234, 32'h0, 0);
    run_op("remu_z",   3'b111, 32'h1234, 32'h0, 0);
    run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("mul_zero", 3'b000, 32'h0, 32'h0, 0);
    run_op("mulhsu",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("mul_poke", 3'b000, 32'h0001_2345, 32'h0000_0F0F, 5);
    run_op("div_poke", 3'b100, 32'hFFFF_F000, 32'd3, 34);

    for (int i = 0; i < 40; i++) begin
      ra = pick_operand();
      rb = pick_operand();
      run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), ra, rb, 0);
    end

    // asynchronous reset in the middle of a divide
    start = 1'b1; funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",   64'(busy),   64'd0);
    chk("arst_done",   64'(done),   64'd0);
    chk("arst_result", 64'(result), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    chk("arst_quiet", 64'(seen_done), 64'd0);
    last_exp = '0;
    @(negedge clk);
    run_op("post_rst", 3'b101, 32'd1000, 32'd7, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
